uart_tx_fifo: RTL and testbench

//  Byte buffer directly upstream of uart_master: bus side pushes bytes at clk rate,

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//    Byte queue in front of uart_master. The bus side pushes words at clock rate.
//    A small FSM pops them one at a time and presents each on data/en_tx.
//    The FSM paces itself on u_tx_done, so the host can queue a burst without
//    polling the serial link. Use one instance per master.
//
// Ports
//    clk        system clock, rising edge
//    rst        asynchronous reset, active-low
//    wr_en      push request, one word per cycle
//    wr_data    word pushed when the push is accepted
//    ovf_clr    clears the sticky overflow flag
//    full       count == DEPTH
//    empty      count == 0
//    count      words queued; the word held in data is not included
//    overflow   sticky flag, set when a push was dropped
//    data       word presented to uart_master; stable while en_tx is high
//    en_tx      transmit request to uart_master
//    u_tx_done  completion level from uart_master
//    busy       FSM is not in IDLE
//
// Configuration
//    UART_TX_FIFO_SYNC_EN  when defined, u_tx_done goes through a 2-flop
//                          synchronizer before the FSM sees it. Use this when
//                          the completion level comes from the clk_tx domain.
//                          When undefined, u_tx_done must be synchronous to clk.
//
// FSM states
//    state     | meaning
//    S_IDLE    | nothing in flight; leave when the queue is non-empty
//    S_LOAD    | pop one word into data
//    S_SEND    | en_tx high, data held; wait for done
//    S_RELEASE | en_tx low; wait for done to drop before the next word

module uart_tx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              ovf_clr,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic [DATA_W-1:0] data,
   output logic              en_tx,
   input  logic              u_tx_done,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_SEND    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              pop;
   logic              push;
   logic              ovf_set;
   logic              done_s;
   logic              en_tx_nxt;
   logic              busy_nxt;

`ifdef UART_TX_FIFO_SYNC_EN
   logic done_meta;
   logic done_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_meta <= 1'b0;
         done_sync <= 1'b0;
      end else begin
         done_meta <= u_tx_done;
         done_sync <= done_meta;
      end
   end

   assign done_s = done_sync;
`else
   assign done_s = u_tx_done;
`endif

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A full FIFO can still accept a push in the same cycle that LOAD pops.
   assign pop     = (state == S_LOAD);
   assign push    = wr_en && (!full || pop);
   assign ovf_set = wr_en && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         data     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            data   <= mem[rd_ptr];
         end
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
         end
         // When a drop and a clear land in the same cycle, the drop wins.
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         en_tx <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         en_tx <= en_tx_nxt;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (done_s) begin
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // Holding here until done drops keeps a held done level from
            // triggering a second send.
            if (!done_s) begin
               state_nxt = empty ? S_IDLE : S_LOAD;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The outputs are registered from the next state, so en_tx and busy change
   // on the same edge as the state.
   always_comb begin
      en_tx_nxt = (state_nxt == S_SEND);
      busy_nxt  = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       ovf_clr;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] data;
   logic       en_tx;
   logic       u_tx_done;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   logic en_prev = 1'b0;

   uart_tx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .ovf_clr   (ovf_clr),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .data      (data),
      .en_tx     (en_tx),
      .u_tx_done (u_tx_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (en_tx && !en_prev) pulses = pulses + 1;
      en_prev = en_tx;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic serve(output logic [7:0] d, output bit ok);
      int n;
      ok = 1'b1;
      n = 0;
      while (!en_tx && n < 40) begin
         tick();
         n++;
      end
      if (!en_tx) begin
         ok = 1'b0;
         d = 8'h00;
         return;
      end
      d = data;
      u_tx_done = 1'b1;
      n = 0;
      while (en_tx && n < 10) begin
         tick();
         n++;
      end
      if (en_tx) ok = 1'b0;
      u_tx_done = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
      checks++; if (en_tx !== 1'b0) begin errors++; $display("FAIL reset_en_tx got %0b exp 0", en_tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
   endtask

   task automatic test_single();
      wr_en = 1'b1; wr_data = 8'h95;
      tick();
      wr_en = 1'b0;
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_n got %0d exp 1", count); end
      checks++; if (en_tx !== 1'b0) begin errors++; $display("FAIL single_en_n got %0b exp 0", en_tx); end
      tick();
      checks++; if (busy !== 1'b1 || en_tx !== 1'b0) begin errors++; $display("FAIL single_load got busy=%0b en=%0b exp busy=1 en=0", busy, en_tx); end
      tick();
      checks++; if (en_tx !== 1'b1) begin errors++; $display("FAIL single_en_n2 got %0b exp 1", en_tx); end
      checks++; if (data !== 8'h95) begin errors++; $display("FAIL single_data got %h exp 95", data); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_pop got %0d exp 0", count); end
      tick(); tick();
      checks++; if (en_tx !== 1'b1) begin errors++; $display("FAIL single_en_hold got %0b exp 1", en_tx); end
      u_tx_done = 1'b1;
      repeat (1 + SL) tick();
      checks++; if (en_tx !== 1'b0) begin errors++; $display("FAIL single_en_fall got %0b exp 0", en_tx); end
      u_tx_done = 1'b0;
      repeat (1 + SL) tick();
      checks++; if (busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL single_idle got busy=%0b empty=%0b exp busy=0 empty=1", busy, empty); end
   endtask

   task automatic test_burst();
      logic [7:0] exp_d [3];
      logic [7:0] d;
      bit ok;
      int p0;
      exp_d[0] = 8'h0B; exp_d[1] = 8'hA5; exp_d[2] = 8'h3C;
      p0 = pulses;
      wr_en = 1'b1; wr_data = 8'h0B; tick();
      wr_data = 8'hA5; tick();
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL burst_count_2 got %0d exp 2", count); end
      wr_data = 8'h3C; tick();
      wr_en = 1'b0;
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL burst_count_peak got %0d exp 2", count); end
      for (int i = 0; i < 3; i++) begin
         serve(d, ok);
         checks++; if (!ok || d !== exp_d[i]) begin errors++; $display("FAIL burst_word%0d got %h ok=%0b exp %h", i, d, ok, exp_d[i]); end
      end
      repeat (8) tick();
      checks++; if (pulses - p0 !== 3) begin errors++; $display("FAIL burst_pulses got %0d exp 3", pulses - p0); end
      checks++; if (busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL burst_idle got busy=%0b empty=%0b exp 0/1", busy, empty); end
   endtask

   task automatic test_full();
      logic [7:0] d;
      bit ok;
      for (int i = 0; i < 18; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_count got %0d full=%0b exp 16/1", count, full); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %0b exp 1", overflow); end
      checks++; if (data !== 8'h10 || en_tx !== 1'b1) begin errors++; $display("FAIL full_data got %h en=%0b exp 10/1", data, en_tx); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clr got %0b exp 0", overflow); end
      wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'hEE; tick();
      wr_en = 1'b0; ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL full_ovf_prio got ovf=%0b count=%0d exp 1/16", overflow, count); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         serve(d, ok);
         checks++; if (!ok || d !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_drain%0d got %h ok=%0b exp %h", i, d, ok, 8'h10 + 8'(i)); end
      end
      repeat (8) tick();
      checks++; if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end got count=%0d empty=%0b busy=%0b exp 0/1/0", count, empty, busy); end
   endtask

   task automatic test_wrap();
      int sizes [3];
      int k;
      logic [7:0] d;
      bit ok;
      sizes[0] = 14; sizes[1] = 13; sizes[2] = 13;
      k = 0;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < sizes[b]; i++) begin
            wr_en = 1'b1; wr_data = 8'h40 + 8'(k + i);
            tick();
         end
         wr_en = 1'b0;
         for (int i = 0; i < sizes[b]; i++) begin
            serve(d, ok);
            checks++; if (!ok || d !== 8'h40 + 8'(k)) begin errors++; $display("FAIL wrap_word%0d got %h ok=%0b exp %h", k, d, ok, 8'h40 + 8'(k)); end
            k++;
         end
      end
      repeat (8) tick();
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_end got count=%0d empty=%0b exp 0/1", count, empty); end
   endtask

   task automatic test_held_done();
      logic [7:0] d;
      bit ok;
      int p0;
      int n;
      p0 = pulses;
      wr_en = 1'b1; wr_data = 8'hA1; tick();
      wr_data = 8'hA2; tick();
      wr_en = 1'b0;
      n = 0;
      while (!en_tx && n < 20) begin tick(); n++; end
      checks++; if (en_tx !== 1'b1 || data !== 8'hA1) begin errors++; $display("FAIL held_first got en=%0b data=%h exp 1/a1", en_tx, data); end
      u_tx_done = 1'b1;
      repeat (50) tick();
      checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL held_pulses got %0d exp 1", pulses - p0); end
      checks++; if (en_tx !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL held_wait got en=%0b count=%0d exp 0/1", en_tx, count); end
      u_tx_done = 1'b0;
      serve(d, ok);
      checks++; if (!ok || d !== 8'hA2) begin errors++; $display("FAIL held_second got %h ok=%0b exp a2", d, ok); end
      repeat (8) tick();
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      bit ok;
      int p0;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'hB0 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      checks++; if (en_tx !== 1'b1 || count !== 5'd3) begin errors++; $display("FAIL rmid_pre got en=%0b count=%0d exp 1/3", en_tx, count); end
      #1 rst = 1'b0;
      #1;
      checks++; if (en_tx !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_async got en=%0b count=%0d empty=%0b busy=%0b exp 0/0/1/0", en_tx, count, empty, busy); end
      #2 rst = 1'b1;
      p0 = pulses;
      repeat (10) tick();
      checks++; if (pulses !== p0 || en_tx !== 1'b0) begin errors++; $display("FAIL rmid_quiet got pulses=%0d en=%0b exp 0/0", pulses - p0, en_tx); end
      wr_en = 1'b1; wr_data = 8'hC7; tick();
      wr_en = 1'b0;
      serve(d, ok);
      checks++; if (!ok || d !== 8'hC7) begin errors++; $display("FAIL rmid_after got %h ok=%0b exp c7", d, ok); end
   endtask

   initial begin
      rst = 1'b0;
      wr_en = 1'b0;
      wr_data = 8'h00;
      ovf_clr = 1'b0;
      u_tx_done = 1'b0;
      #1;
      test_reset();
      tick(); tick();
      rst = 1'b1;
      tick();
      test_single();
      tick();
      test_burst();
      test_full();
      test_wrap();
      test_held_done();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
